dcache_controller: RTL
======================

# dcache_controller

Direct-mapped, write-through, no-write-allocate data cache controller placed between the CPU load/store stage and `datamemory`. It holds a cached copy of memory blocks of 2**BLOCK_SIZE words, serves read hits combinationally, and refills a whole block in one memory access on a read miss. It forwards every write to memory and runs a multi-cycle invalidate walk on flush. It also keeps read hit and miss counters for performance measurement.

## Interface
- `DATA_WIDTH`, 32: word width.
- `ADDRESS_WIDTH`, 30: word-address width, shared with `datamemory`.
- `BLOCK_SIZE`, 3: log2 of words per block; must equal `datamemory`'s value.
- `SET_BITS`, 4: log2 of the number of cache lines.
- `COUNTER_WIDTH`, 32: width of the hit and miss counters.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `cpu_addr` in ADDRESS_WIDTH: word address of the request.
- `cpu_read` in 1: load request.
- `cpu_write` in 1: store request.
- `cpu_wdata` in DATA_WIDTH: store data.
- `flush` in 1: request to invalidate all lines.
- `cpu_rdata` out DATA_WIDTH: load data; valid when `cpu_read`=1 and `stall`=0.
- `stall` out 1: CPU must hold its request and its pipeline.
- `mem_address` out ADDRESS_WIDTH: connects to `datamemory.address`.
- `mem_write_data` out DATA_WIDTH: connects to `datamemory.write_data`.
- `mem_write_enable` out 1: connects to `datamemory.write_enable`.
- `mem_read_data` in DATA_WIDTH*2**BLOCK_SIZE: block read from `datamemory`. Word i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `hit_count` out COUNTER_WIDTH: number of read hits.
- `miss_count` out COUNTER_WIDTH: number of read misses.

## Operation
- **Address split:**
  - offset = `cpu_addr`[BLOCK_SIZE-1:0]
  - index = next SET_BITS bits
  - tag = remaining upper bits
- **Line contents:** each line holds a valid bit, a tag and a block of 2**BLOCK_SIZE words.
- **Hit:** the line at index is valid and its tag equals the request tag.
- **States:**
  - IDLE → FLUSH when `flush`=1. Flush has priority over any CPU request.
  - IDLE → REFILL on a read miss.
  - REFILL → IDLE unconditionally after one cycle.
  - FLUSH → IDLE after the invalidate counter reaches 2**SET_BITS-1.
- **IDLE, read hit:**
  - `cpu_rdata` is the addressed word, combinationally.
  - `stall`=0.
  - `hit_count` increments.
- **IDLE, read miss:**
  - `stall`=1.
  - `miss_count` increments, once per miss.
- **REFILL:**
  - `mem_address` = {`cpu_addr`[ADDRESS_WIDTH-1:BLOCK_SIZE], zeros}.
  - At the clock edge, the line is loaded from `mem_read_data`, its tag is set and valid is set.
  - `stall`=1.
  - The CPU holds its request, so the next IDLE cycle is a hit. That hit is counted in `hit_count`.
- **Write (IDLE, `cpu_write`=1):**
  - `mem_write_enable`=1, `mem_address`=`cpu_addr`, `mem_write_data`=`cpu_wdata`, all combinationally.
  - `stall`=0.
  - On a hit, the cached word is updated at the same edge.
  - On a miss, the line is left unchanged (no allocate).
- **Read and write together:** `cpu_read` and `cpu_write` both high is illegal. The write is performed and the read is ignored: no count, `cpu_rdata` undefined.
- **FLUSH:**
  - `stall`=1.
  - One line is invalidated per cycle, indices 0 up to 2**SET_BITS-1.
  - CPU requests are ignored during the walk.
  - `flush` asserted during FLUSH has no effect.
- **Write enable outside IDLE:** `mem_write_enable` is 0 in REFILL and FLUSH.
- **Counters:** saturate at all ones; they do not wrap.
- **Reset:** all valid bits cleared, state IDLE, flush counter 0, both counters 0. Reset during REFILL or FLUSH abandons the operation, and all lines are invalid afterwards.

## Timing
- **Output reset values:**
  - `stall`=0 while `cpu_read` and `flush` are low.
  - `mem_write_enable`=0 and `mem_address`=`cpu_addr`.
  - `hit_count`=0, `miss_count`=0.
- **Read hit:** 0 cycles of latency, data in the same cycle.
- **Read miss:** 2 cycles total. Cycle 0 is the IDLE miss (stall), cycle 1 is REFILL (stall), and data is returned in cycle 2.
- **Write:** 1 cycle, never stalls. Memory and the cached word are updated at the request edge.
- **Flush:** `stall` is high for exactly 1 + 2**SET_BITS cycles, starting in the cycle `flush` is sampled.
- **Visibility:** a write in cycle N is visible to a read hit in cycle N+1.

## Structure
- `cache_pkg` holds:
  - the `state_t` enum (IDLE, REFILL, FLUSH);
  - helper functions `addr_offset`, `addr_index`, `addr_tag`.
- Sub-module `dcache_store`:
  - valid, tag and data arrays with an asynchronous clear of the valid bits;
  - one combinational read port;
  - one port that writes either a whole line or a single word;
  - one port that invalidates a single line.
- The FSM, the flush counter and the perf counters live in `dcache_controller`.

## Test plan
- **Cold read:** reset; read `cpu_addr`=0x13 with memory word 0x13=0xDEADBEEF. Expected: stall for 2 cycles, `cpu_rdata`=0xDEADBEEF in cycle 2, `miss_count`=1, `hit_count`=1.
- **Block reuse:** after the cold read, read 0x10 through 0x17. Expected: 8 hits with no stall, and memory values returned.
- **Write hit then read:** write 0x12345678 to 0x13, then read 0x13 in the next cycle. Expected: memory word 0x13 updated, read hit returns 0x12345678.
- **Conflict and no-allocate:**
  - Write to a conflicting address 0x113 (same index, different tag). Expected: no stall, memory updated, line 0x10 still hits.
  - Then read 0x113. Expected: miss, refill, returns the written value.
- **Flush:** flush with SET_BITS=4. Expected: `stall` high for 17 cycles. A later read of 0x13 misses.
- **Reset mid-operation:**
  - Reset asserted in the middle of REFILL. Expected: counters 0, state IDLE, the next read misses.
  - Saturation: force `miss_count` to all ones. Expected: it does not wrap.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the direct-mapped data cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    function automatic logic [63:0] addr_offset(input logic [63:0] addr,
                                                input int unsigned block_size);
        return addr & ((64'd1 << block_size) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_index(input logic [63:0] addr,
                                               input int unsigned block_size,
                                               input int unsigned set_bits);
        return (addr >> block_size) & ((64'd1 << set_bits) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_tag(input logic [63:0] addr,
                                             input int unsigned block_size,
                                             input int unsigned set_bits);
        return addr >> (block_size + set_bits);
    endfunction

endpackage

// File: rtl/dcache_store.sv
// Valid/tag/data arrays: one combinational read port, a line-or-word write
// port and a single-line invalidate port; valid bits clear asynchronously.
module dcache_store #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BLOCK_SIZE = 3,
    parameter int unsigned SET_BITS   = 4,
    parameter int unsigned TAG_W      = 23,
    parameter int unsigned BLOCK_W    = DATA_WIDTH * (2 ** BLOCK_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SET_BITS-1:0]   rd_index,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [BLOCK_W-1:0]    rd_block,
    input  logic                  wr_line,
    input  logic                  wr_word,
    input  logic [SET_BITS-1:0]   wr_index,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [BLOCK_W-1:0]    wr_block,
    input  logic [BLOCK_SIZE-1:0] wr_offset,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  inv_en,
    input  logic [SET_BITS-1:0]   inv_index
);

    localparam int unsigned SETS = 2 ** SET_BITS;

    logic [SETS-1:0]    valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [TAG_W-1:0]   tag_d  [SETS];
    logic [BLOCK_W-1:0] data_q [SETS];
    logic [BLOCK_W-1:0] data_d [SETS];

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_block = data_q[rd_index];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_line) begin
            valid_d[wr_index] = 1'b1;
            tag_d[wr_index]   = wr_tag;
            data_d[wr_index]  = wr_block;
        end
        if (wr_word) begin
            data_d[wr_index][32'(wr_offset) * DATA_WIDTH +: DATA_WIDTH] = wr_data;
        end
        if (inv_en) begin
            valid_d[inv_index] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data need no reset: they are only meaningful behind a valid bit.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller
// with single-access block refill, flush walk and saturating hit/miss counters.
module dcache_controller
    import cache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 30,
    parameter int unsigned BLOCK_SIZE    = 3,
    parameter int unsigned SET_BITS      = 4,
    parameter int unsigned COUNTER_WIDTH = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [ADDRESS_WIDTH-1:0]               cpu_addr,
    input  logic                                   cpu_read,
    input  logic                                   cpu_write,
    input  logic [DATA_WIDTH-1:0]                  cpu_wdata,
    input  logic                                   flush,
    output logic [DATA_WIDTH-1:0]                  cpu_rdata,
    output logic                                   stall,
    output logic [ADDRESS_WIDTH-1:0]               mem_address,
    output logic [DATA_WIDTH-1:0]                  mem_write_data,
    output logic                                   mem_write_enable,
    input  logic [DATA_WIDTH*(2**BLOCK_SIZE)-1:0]  mem_read_data,
    output logic [COUNTER_WIDTH-1:0]               hit_count,
    output logic [COUNTER_WIDTH-1:0]               miss_count
);

    localparam int unsigned TAG_W   = ADDRESS_WIDTH - BLOCK_SIZE - SET_BITS;
    localparam int unsigned BLOCK_W = DATA_WIDTH * (2 ** BLOCK_SIZE);

    state_t                  state_q, state_d;
    logic [SET_BITS-1:0]     flush_cnt_q, flush_cnt_d;
    logic [COUNTER_WIDTH-1:0] hit_q, hit_d, miss_q, miss_d;

    logic [BLOCK_SIZE-1:0]   offset;
    logic [SET_BITS-1:0]     index;
    logic [TAG_W-1:0]        tag;
    logic                    rd_valid, hit;
    logic [TAG_W-1:0]        rd_tag;
    logic [BLOCK_W-1:0]      rd_block;
    logic                    wr_line, wr_word, inv_en;

    assign offset = BLOCK_SIZE'(addr_offset(64'(cpu_addr), BLOCK_SIZE));
    assign index  = SET_BITS'(addr_index(64'(cpu_addr), BLOCK_SIZE, SET_BITS));
    assign tag    = TAG_W'(addr_tag(64'(cpu_addr), BLOCK_SIZE, SET_BITS));
    assign hit    = rd_valid && (rd_tag == tag);

    dcache_store #(
        .DATA_WIDTH(DATA_WIDTH),
        .BLOCK_SIZE(BLOCK_SIZE),
        .SET_BITS  (SET_BITS),
        .TAG_W     (TAG_W),
        .BLOCK_W   (BLOCK_W)
    ) u_store (
        .clk      (clk),
        .rst      (rst),
        .rd_index (index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_block (rd_block),
        .wr_line  (wr_line),
        .wr_word  (wr_word),
        .wr_index (index),
        .wr_tag   (tag),
        .wr_block (mem_read_data),
        .wr_offset(offset),
        .wr_data  (cpu_wdata),
        .inv_en   (inv_en),
        .inv_index(flush_cnt_q)
    );

    always_comb begin
        state_d          = state_q;
        flush_cnt_d      = flush_cnt_q;
        hit_d            = hit_q;
        miss_d           = miss_q;
        stall            = 1'b0;
        mem_address      = cpu_addr;
        mem_write_data   = cpu_wdata;
        mem_write_enable = 1'b0;
        wr_line          = 1'b0;
        wr_word          = 1'b0;
        inv_en           = 1'b0;
        cpu_rdata        = rd_block[32'(offset) * DATA_WIDTH +: DATA_WIDTH];

        unique case (state_q)
            IDLE: begin
                if (flush) begin
                    stall   = 1'b1;
                    state_d = FLUSH;
                end else if (cpu_write) begin
                    // Write-through always; update the cached word only on a hit.
                    mem_write_enable = 1'b1;
                    wr_word          = hit;
                end else if (cpu_read) begin
                    if (hit) begin
                        hit_d = (hit_q == '1) ? hit_q : hit_q + COUNTER_WIDTH'(1);
                    end else begin
                        stall   = 1'b1;
                        miss_d  = (miss_q == '1) ? miss_q : miss_q + COUNTER_WIDTH'(1);
                        state_d = REFILL;
                    end
                end
            end
            REFILL: begin
                stall       = 1'b1;
                mem_address = {cpu_addr[ADDRESS_WIDTH-1:BLOCK_SIZE], BLOCK_SIZE'(0)};
                wr_line     = 1'b1;
                state_d     = IDLE;
            end
            FLUSH: begin
                stall       = 1'b1;
                inv_en      = 1'b1;
                flush_cnt_d = flush_cnt_q + SET_BITS'(1);
                if (flush_cnt_q == '1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
            hit_q       <= '0;
            miss_q      <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;

endmodule
